// File: rtl/core_regs_pkg.sv
// Shared register-bank definitions for the matrix-multiply core: register
// indices, default sizes and the default reset image.
package core_regs_pkg;

    localparam int REG_COUNT_DEF = 11;
    localparam int REG_WIDTH_DEF = 12;

    localparam int IDX_R      = 0;
    localparam int IDX_ROW    = 1;
    localparam int IDX_CAT    = 2;
    localparam int IDX_CB     = 3;
    localparam int IDX_RNOW   = 4;
    localparam int IDX_CATNOW = 5;
    localparam int IDX_CBNOW  = 6;
    localparam int IDX_ALPHAP = 7;
    localparam int IDX_BETAP  = 8;
    localparam int IDX_GAMMAP = 9;
    localparam int IDX_TOTAL  = 10;

    // Entry i lives at bits [i*12 +: 12]; betap = 900, gammap = 1600, rest zero.
    localparam logic [REG_COUNT_DEF*REG_WIDTH_DEF-1:0] RESET_IMAGE_DEF =
        {12'd0, 12'd1600, 12'd900, 96'd0};

endpackage

// File: rtl/onehot_sel.sv
// Decodes an N-bit select vector into its lowest set index plus
// one-hot / multi-hot flags.
module onehot_sel #(
    parameter int N     = 11,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     vec,
    output logic [IDX_W-1:0] idx,
    output logic             is_onehot,
    output logic             is_multi
);

    always_comb begin
        idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx = IDX_W'(i);
            end
        end
    end

    // Clearing the lowest set bit leaves something only when two or more are set.
    assign is_multi  = (vec & (vec - 1'b1)) != '0;
    assign is_onehot = (vec != '0) && !is_multi;

endmodule

// File: rtl/loop_reg_file.sv
// Per-core register file: bus writes, per-register clears, hardware loop
// counters with limit wrap, and read/write selection error flags.
module loop_reg_file
    import core_regs_pkg::*;
#(
    parameter int                               REG_COUNT   = REG_COUNT_DEF,
    parameter int                               REG_WIDTH   = REG_WIDTH_DEF,
    parameter logic [REG_COUNT*REG_WIDTH-1:0]   RESET_VALS  = RESET_IMAGE_DEF,
    parameter int                               CORE_NUMBER = 0,
    parameter int                               NUM_LOOPS   = 3,
    parameter int                               CNT_BASE    = IDX_RNOW,
    parameter int                               LIM_BASE    = IDX_ROW,
    parameter int                               DEFAULT_RD  = IDX_BETAP
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [REG_COUNT-1:0] write_en,
    input  logic [REG_COUNT-1:0] clr_en,
    input  logic [NUM_LOOPS-1:0] inc_en,
    input  logic [REG_COUNT-1:0] read_en,
    input  logic [REG_WIDTH-1:0] datain,
    output logic [REG_WIDTH-1:0] dataout,
    output logic [NUM_LOOPS-1:0] wrap,
    output logic                 rd_err,
    output logic                 wr_conflict
);

    localparam int IDX_W = (REG_COUNT > 1) ? $clog2(REG_COUNT) : 1;

    logic [REG_WIDTH-1:0] regs_q [REG_COUNT];
    logic [REG_WIDTH-1:0] regs_d [REG_COUNT];
    logic [NUM_LOOPS-1:0] wrap_q, wrap_d;
    logic                 wr_conflict_q, wr_conflict_d;

    logic [IDX_W-1:0] wr_idx, rd_idx;
    logic             wr_onehot, wr_multi, wr_any;
    logic             rd_onehot, rd_multi;

    function automatic logic [REG_WIDTH-1:0] reset_val(input int i);
        if (i == REG_COUNT - 1) begin
            return REG_WIDTH'(CORE_NUMBER);
        end
        return RESET_VALS[i*REG_WIDTH +: REG_WIDTH];
    endfunction

    onehot_sel #(.N(REG_COUNT), .IDX_W(IDX_W)) u_wr_sel (
        .vec       (write_en),
        .idx       (wr_idx),
        .is_onehot (wr_onehot),
        .is_multi  (wr_multi)
    );

    onehot_sel #(.N(REG_COUNT), .IDX_W(IDX_W)) u_rd_sel (
        .vec       (read_en),
        .idx       (rd_idx),
        .is_onehot (rd_onehot),
        .is_multi  (rd_multi)
    );

    assign wr_any = wr_onehot || wr_multi;

    logic [NUM_LOOPS-1:0] inc_wrap;
    logic [NUM_LOOPS-1:0] inc_blocked;
    logic [REG_WIDTH-1:0] inc_val [NUM_LOOPS];

    for (genvar k = 0; k < NUM_LOOPS; k++) begin : g_loop
        localparam int CI = CNT_BASE + k;
        localparam int LI = LIM_BASE + k;
        logic [REG_WIDTH:0] cnt_plus1;

        // One extra bit so an all-ones counter cannot overflow the compare.
        assign cnt_plus1      = {1'b0, regs_q[CI]} + (REG_WIDTH+1)'(1);
        assign inc_wrap[k]    = cnt_plus1 >= {1'b0, regs_q[LI]};
        assign inc_val[k]     = inc_wrap[k] ? '0 : cnt_plus1[REG_WIDTH-1:0];
        assign inc_blocked[k] = clr_en[CI] || (wr_any && (int'(wr_idx) == CI));
    end

    always_comb begin
        regs_d        = regs_q;
        wrap_d        = '0;
        wr_conflict_d = wr_multi;
        for (int k = 0; k < NUM_LOOPS; k++) begin
            if (inc_en[k] && !inc_blocked[k]) begin
                regs_d[CNT_BASE+k] = inc_val[k];
                wrap_d[k]          = inc_wrap[k];
            end
        end
        for (int i = 0; i < REG_COUNT; i++) begin
            if (clr_en[i]) begin
                regs_d[i] = '0;
            end
        end
        // Applied last so a write overrides clear and increment on its target.
        if (wr_any) begin
            regs_d[wr_idx] = datain;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < REG_COUNT; i++) begin
                regs_q[i] <= reset_val(i);
            end
            wrap_q        <= '0;
            wr_conflict_q <= 1'b0;
        end else begin
            regs_q        <= regs_d;
            wrap_q        <= wrap_d;
            wr_conflict_q <= wr_conflict_d;
        end
    end

    assign dataout     = rd_onehot ? regs_q[rd_idx] : regs_q[DEFAULT_RD];
    assign rd_err      = rd_multi || (read_en == '0);
    assign wrap        = wrap_q;
    assign wr_conflict = wr_conflict_q;

endmodule

// File: tb/tb_loop_reg_file.sv
// Bench for loop_reg_file: directed vectors with literal expectations plus a
// per-cycle comparison against an integer-level behavioural model.
module tb_loop_reg_file;

    logic        clk = 1'b0;
    logic        reset;
    logic [10:0] write_en, clr_en, read_en;
    logic [2:0]  inc_en;
    logic [11:0] datain;
    logic [11:0] dataout;
    logic [2:0]  wrap;
    logic        rd_err, wr_conflict;

    int checks = 0;
    int errors = 0;

    loop_reg_file #(.CORE_NUMBER(3)) dut (
        .clk         (clk),
        .reset       (reset),
        .write_en    (write_en),
        .clr_en      (clr_en),
        .inc_en      (inc_en),
        .read_en     (read_en),
        .datain      (datain),
        .dataout     (dataout),
        .wrap        (wrap),
        .rd_err      (rd_err),
        .wr_conflict (wr_conflict)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: registers as plain integers.
    int m_regs [11];
    int m_wrap;
    int m_wc;
    int nr [11];
    int wrote, c, l;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 11; i++) m_regs[i] = 0;
            m_regs[8] = 900;
            m_regs[9] = 1600;
            m_regs[10] = 3;
            m_wrap = 0;
            m_wc = 0;
        end else begin
            nr = m_regs;
            wrote = -1;
            for (int i = 10; i >= 0; i--) if (write_en[i]) wrote = i;
            m_wrap = 0;
            for (int k = 0; k < 3; k++) begin
                c = 4 + k;
                l = 1 + k;
                if (inc_en[k] && !clr_en[c] && wrote != c) begin
                    if (m_regs[c] + 1 >= m_regs[l]) begin
                        nr[c] = 0;
                        m_wrap += (1 << k);
                    end else begin
                        nr[c] = m_regs[c] + 1;
                    end
                end
            end
            for (int i = 0; i < 11; i++) if (clr_en[i] && wrote != i) nr[i] = 0;
            if (wrote >= 0) nr[wrote] = int'(datain);
            m_regs = nr;
            m_wc = ($countones(write_en) > 1) ? 1 : 0;
        end
    end

    int cmp_cnt, cmp_sel;
    always @(negedge clk) begin
        cmp_cnt = $countones(read_en);
        cmp_sel = 8;
        if (cmp_cnt == 1) for (int i = 0; i < 11; i++) if (read_en[i]) cmp_sel = i;
        chk("model_dataout", int'(dataout), m_regs[cmp_sel]);
        chk("model_rd_err", int'(rd_err), (cmp_cnt != 1) ? 1 : 0);
        chk("model_wrap", int'(wrap), m_wrap);
        chk("model_wr_conflict", int'(wr_conflict), m_wc);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic peek(input int idx, input int exp, input string name);
        read_en = 11'(1 << idx);
        #1;
        chk(name, int'(dataout), exp);
    endtask

    int rst_img [11] = '{0, 0, 0, 0, 0, 0, 0, 0, 900, 1600, 3};

    initial begin
        reset = 1'b1;
        write_en = '0; clr_en = '0; inc_en = '0; read_en = 11'(1 << 8); datain = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_wrap_held", int'(wrap), 0);
        reset = 1'b0;
        for (int i = 0; i < 11; i++) peek(i, rst_img[i], "reset_reg");
        chk("reset_wrap", int'(wrap), 0);
        chk("reset_wr_conflict", int'(wr_conflict), 0);

        // Loop 0: limit row=3, three increments wrap on the third.
        write_en = 11'(1 << 1); datain = 12'd3; tick();
        write_en = '0; read_en = 11'(1 << 4); inc_en = 3'b001;
        tick(); chk("rnow_1", int'(dataout), 1); chk("wrap_a", int'(wrap), 0);
        tick(); chk("rnow_2", int'(dataout), 2); chk("wrap_b", int'(wrap), 0);
        tick(); chk("rnow_wrap", int'(dataout), 0); chk("wrap_c", int'(wrap), 1);
        inc_en = '0;
        tick(); chk("wrap_end", int'(wrap), 0);

        // Multi-bit write: lowest index wins, conflict pulses once.
        write_en = 11'b00000001010; datain = 12'd77; tick();
        write_en = '0;
        chk("wr_conflict_hi", int'(wr_conflict), 1);
        peek(1, 77, "row_77");
        peek(3, 0, "cb_unchanged");
        tick(); chk("wr_conflict_lo", int'(wr_conflict), 0);

        // Write beats increment on the same counter.
        write_en = 11'(1 << 5); datain = 12'd5; inc_en = 3'b010; tick();
        write_en = '0; inc_en = '0;
        peek(5, 5, "catnow_write_wins"); chk("wrap_write_wins", int'(wrap), 0);
        // Limit cAT=0: next increment wraps immediately.
        inc_en = 3'b010; tick(); inc_en = '0;
        peek(5, 0, "catnow_lim0"); chk("wrap_lim0", int'(wrap), 3'b010);

        // Clear beats increment.
        inc_en = 3'b001; tick();
        peek(4, 1, "rnow_pre_clr");
        clr_en = 11'(1 << 4); tick();
        clr_en = '0; inc_en = '0;
        peek(4, 0, "rnow_clr"); chk("wrap_clr", int'(wrap), 0);

        // Invalid read selects fall back to betap.
        read_en = '0; #1;
        chk("rd_none_data", int'(dataout), 900); chk("rd_none_err", int'(rd_err), 1);
        read_en = 11'b00000000011; #1;
        chk("rd_multi_data", int'(dataout), 900); chk("rd_multi_err", int'(rd_err), 1);

        // All-ones counter with all-ones limit wraps cleanly.
        write_en = 11'(1 << 3); datain = 12'hFFF; tick();
        write_en = 11'(1 << 6); tick();
        write_en = '0; inc_en = 3'b100; tick(); inc_en = '0;
        peek(6, 0, "cbnow_allones"); chk("wrap_allones", int'(wrap), 3'b100);

        // Asynchronous reset with a wrap and a conflict pending.
        write_en = 11'(1 << 4); datain = 12'd76; tick();
        write_en = 11'b00110000000; datain = 12'd11; inc_en = 3'b001; tick();
        write_en = '0; inc_en = '0;
        chk("pre_rst_wrap", int'(wrap), 1);
        chk("pre_rst_conflict", int'(wr_conflict), 1);
        peek(7, 11, "pre_rst_alphap");
        reset = 1'b1; #1;
        chk("async_rst_wrap", int'(wrap), 0);
        chk("async_rst_conflict", int'(wr_conflict), 0);
        peek(1, 0, "async_rst_row");
        peek(7, 0, "async_rst_alphap");
        peek(10, 3, "async_rst_total");
        tick();
        reset = 1'b0;
        repeat (3) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
